// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer for the EX stage: drives the comparator mode, waits for operands, resolves, and redirects/flushes.
// Optional statistics counters are compiled in when BRANCH_STATS_EN is defined.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WAIT_MAX     = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_target,
    input  logic        opnd_ready,
    input  logic        brlt,
    input  logic        breq,
    output logic        brun,
    output logic        stall,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        br_done,
    output logic        br_taken,
    output logic        br_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_stall_cyc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CMP,
        S_FLUSH
    } state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

    state_t      state_q;
    logic [2:0]  f3_q;
    logic [31:0] target_q;
    logic [7:0]  wcnt_q;
    logic [3:0]  fcnt_q;
    logic        brun_q;
    logic        pc_sel_q;
    logic        flush_q;
    logic        done_q;
    logic        taken_q;
    logic        err_q;
    logic        cmp_taken;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return f3[2] & ~f3[1];
    endfunction

    // funct3[0] inverts the base condition (BNE/BGE/BGEU).
    function automatic logic f3_taken(input logic [2:0] f3, input logic lt, input logic eq);
        logic base;
        case (f3[2:1])
            2'b00:        base = eq;
            2'b10, 2'b11: base = lt;
            default:      base = 1'b0;
        endcase
        return base ^ f3[0];
    endfunction

    assign cmp_taken = f3_taken(f3_q, brlt, breq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            target_q <= '0;
            wcnt_q   <= '0;
            fcnt_q   <= '0;
            brun_q   <= 1'b0;
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_sel_q <= 1'b0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (br_valid) begin
                        f3_q     <= br_funct3;
                        target_q <= br_target;
                        if (!f3_legal(br_funct3)) begin
                            err_q <= 1'b1;
                        end else if (opnd_ready) begin
                            state_q <= S_CMP;
                            brun_q  <= f3_signed(br_funct3);
                        end else begin
                            state_q <= S_WAIT;
                            wcnt_q  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    // operands arriving on the expiry cycle still win over the watchdog
                    if (opnd_ready) begin
                        state_q <= S_CMP;
                        brun_q  <= f3_signed(f3_q);
                    end else if (wcnt_q == WAIT_LAST) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_CMP: begin
                    done_q <= 1'b1;
                    if (cmp_taken) begin
                        state_q  <= S_FLUSH;
                        pc_sel_q <= 1'b1;
                        taken_q  <= 1'b1;
                        flush_q  <= 1'b1;
                        fcnt_q   <= 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q == FLUSH_LAST) begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Accept-cycle stall is combinational so the front end holds in the same cycle.
    assign stall = rst_n & (((state_q == S_IDLE) & br_valid & f3_legal(br_funct3))
                            | (state_q != S_IDLE));

    assign brun        = brun_q;
    assign pc_sel      = pc_sel_q;
    assign pc_target   = target_q;
    assign flush_if_id = flush_q;
    assign flush_id_ex = flush_q;
    assign br_done     = done_q;
    assign br_taken    = taken_q;
    assign br_err      = err_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] st_br_q, st_br_d;
    logic [CNT_W-1:0] st_tk_q, st_tk_d;
    logic [CNT_W-1:0] st_sc_q, st_sc_d;

    always_comb begin
        st_br_d = st_br_q;
        st_tk_d = st_tk_q;
        st_sc_d = st_sc_q;
        if ((state_q == S_CMP) && (st_br_q != '1)) begin
            st_br_d = st_br_q + 1'b1;
        end
        if ((state_q == S_CMP) && cmp_taken && (st_tk_q != '1)) begin
            st_tk_d = st_tk_q + 1'b1;
        end
        if ((state_q == S_WAIT) && (st_sc_q != '1)) begin
            st_sc_d = st_sc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_br_q <= '0;
            st_tk_q <= '0;
            st_sc_q <= '0;
        end else begin
            st_br_q <= st_br_d;
            st_tk_q <= st_tk_d;
            st_sc_q <= st_sc_d;
        end
    end

    assign stat_branches  = st_br_q;
    assign stat_taken     = st_tk_q;
    assign stat_stall_cyc = st_sc_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a cycle-indexed expectation schedule built from branch latency rules,
// checked every cycle, plus hand-computed literal pins.
module tb_branch_ctrl;

    localparam int FC = 2;
    localparam int WM = 8;
    localparam int N  = 1024;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  br_funct3;
    logic [31:0] br_target;
    logic        opnd_ready;
    logic        brlt;
    logic        breq;
    logic        brun;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        br_done;
    logic        br_taken;
    logic        br_err;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_taken;
    logic [15:0] stat_stall_cyc;
`endif

    branch_ctrl #(
        .FLUSH_CYCLES(FC),
        .WAIT_MAX(WM),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .br_valid(br_valid),
        .br_funct3(br_funct3),
        .br_target(br_target),
        .opnd_ready(opnd_ready),
        .brlt(brlt),
        .breq(breq),
        .brun(brun),
        .stall(stall),
        .pc_sel(pc_sel),
        .pc_target(pc_target),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .br_done(br_done),
        .br_taken(br_taken),
        .br_err(br_err)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_taken(stat_taken),
        .stat_stall_cyc(stat_stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs per cycle; brun/pc_target entries carry the held value forward.
    bit          e_stall [N];
    bit          e_pcsel [N];
    bit          e_flush [N];
    bit          e_done  [N];
    bit          e_taken [N];
    bit          e_err   [N];
    bit          e_brun  [N];
    logic [31:0] e_tgt   [N];

    logic        a_stall [N];
    logic        a_pcsel [N];
    logic        a_flush [N];
    logic        a_done  [N];
    logic        a_taken [N];
    logic        a_err   [N];
    logic        a_brun  [N];

    initial begin
        for (int i = 0; i < N; i++) e_tgt[i] = '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < N) begin
            a_stall[cyc] = stall;
            a_pcsel[cyc] = pc_sel;
            a_flush[cyc] = flush_if_id;
            a_done[cyc]  = br_done;
            a_taken[cyc] = br_taken;
            a_err[cyc]   = br_err;
            a_brun[cyc]  = brun;
            check("stall", {31'd0, stall}, {31'd0, e_stall[cyc]});
            check("pc_sel", {31'd0, pc_sel}, {31'd0, e_pcsel[cyc]});
            check("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_flush[cyc]});
            check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e_flush[cyc]});
            check("br_done", {31'd0, br_done}, {31'd0, e_done[cyc]});
            check("br_taken", {31'd0, br_taken}, {31'd0, e_taken[cyc]});
            check("br_err", {31'd0, br_err}, {31'd0, e_err[cyc]});
            check("brun", {31'd0, brun}, {31'd0, e_brun[cyc]});
            check("pc_target", pc_target, e_tgt[cyc]);
        end
    end

    // Schedule one branch accepted in cycle c0 whose operands become ready d cycles later.
    function automatic void model_branch(input int c0, input logic [2:0] f3, input logic [31:0] tgt,
                                         input int d, input logic lt, input logic eq, output int last);
        int  cmp;
        bit  tk;
        bit  sgn;
        for (int k = c0 + 1; k < N; k++) e_tgt[k] = tgt;
        if (f3 == 3'b010 || f3 == 3'b011) begin
            e_err[c0 + 1] = 1'b1;
            last = c0;
            return;
        end
        if (d > WM) begin
            for (int k = c0; k <= c0 + WM; k++) e_stall[k] = 1'b1;
            e_err[c0 + WM + 1] = 1'b1;
            last = c0 + WM;
            return;
        end
        cmp = c0 + d + 1;
        sgn = (f3 == 3'b100) || (f3 == 3'b101);
        for (int k = cmp; k < N; k++) e_brun[k] = sgn;
        case (f3)
            3'b000:  tk = eq;
            3'b001:  tk = !eq;
            3'b100:  tk = lt;
            3'b101:  tk = !lt;
            3'b110:  tk = lt;
            default: tk = !lt;
        endcase
        e_done[cmp + 1]  = 1'b1;
        e_taken[cmp + 1] = tk;
        if (tk) begin
            e_pcsel[cmp + 1] = 1'b1;
            for (int j = 1; j <= FC; j++) e_flush[cmp + j] = 1'b1;
            last = cmp + FC;
        end else begin
            last = cmp;
        end
        for (int k = c0; k <= last; k++) e_stall[k] = 1'b1;
    endfunction

    function automatic void model_reset(input int r);
        for (int k = r; k < N; k++) begin
            e_stall[k] = 0; e_pcsel[k] = 0; e_flush[k] = 0; e_done[k] = 0;
            e_taken[k] = 0; e_err[k] = 0; e_brun[k] = 0; e_tgt[k] = '0;
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        br_valid = 1'b0; opnd_ready = 1'b0; brlt = 1'b0; breq = 1'b0;
        repeat (n) next_cycle();
    endtask

    // Comparator inputs carry the inverse of the intended value except in the CMP cycle.
    task automatic run_br(input logic [2:0] f3, input logic [31:0] tgt, input int d,
                          input logic lt, input logic eq, input int abort_at);
        int c0;
        int cmp;
        int last;
        c0  = cyc;
        cmp = c0 + d + 1;
        model_branch(c0, f3, tgt, d, lt, eq, last);
        for (int k = c0; k <= last; k++) begin
            if (k == abort_at) begin
                #1;
                rst_n = 1'b0;
                model_reset(k);
                br_valid = 1'b0; opnd_ready = 1'b0;
                break;
            end
            br_valid   = 1'b1;
            br_funct3  = f3;
            br_target  = tgt;
            opnd_ready = ((k - c0) >= d);
            brlt       = (k == cmp) ? lt : !lt;
            breq       = (k == cmp) ? eq : !eq;
            next_cycle();
        end
        br_valid = 1'b0; opnd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
`ifdef BRANCH_STATS_EN
        logic [15:0] sc0;
`endif
        br_valid = 0; br_funct3 = '0; br_target = '0; opnd_ready = 0; brlt = 0; breq = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        c0 = cyc;
        run_br(3'b000, 32'h0000_0100, 0, 1'b0, 1'b1, -1);
        idle(2);
        check("beq_pcsel_c2", {31'd0, a_pcsel[c0+2]}, 32'd1);
        check("beq_done_taken_c2", {30'd0, a_done[c0+2], a_taken[c0+2]}, 32'd3);
        check("beq_flush_c2_c3", {30'd0, a_flush[c0+2], a_flush[c0+3]}, 32'd3);
        check("beq_idle_c4", {30'd0, a_flush[c0+4], a_stall[c0+4]}, 32'd0);
        check("beq_target", pc_target, 32'h0000_0100);

`ifdef BRANCH_STATS_EN
        sc0 = stat_stall_cyc;
`endif
        c0 = cyc;
        run_br(3'b101, 32'h0000_2000, 3, 1'b0, 1'b0, -1);
        idle(2);
        check("bge_wait_stall", {28'd0, a_stall[c0+1], a_stall[c0+2], a_stall[c0+3], a_done[c0+4]}, 32'hE);
        check("bge_brun_cmp", {31'd0, a_brun[c0+4]}, 32'd1);
        check("bge_pcsel_c5", {31'd0, a_pcsel[c0+5]}, 32'd1);
`ifdef BRANCH_STATS_EN
        check("bge_stat_stall", {16'd0, stat_stall_cyc - sc0}, 32'd3);
`endif

        c0 = cyc;
        run_br(3'b110, 32'h0000_3000, 0, 1'b0, 1'b0, -1);
        idle(2);
        check("bltu_brun_cmp", {31'd0, a_brun[c0+1]}, 32'd0);
        check("bltu_done_nt_c2", {30'd0, a_done[c0+2], a_taken[c0+2]}, 32'd2);
        check("bltu_nostall_c2", {30'd0, a_stall[c0+2], a_pcsel[c0+2]}, 32'd0);

        run_br(3'b001, 32'h0000_4000, 0, 1'b0, 1'b1, -1);
        run_br(3'b110, 32'h0000_4444, 1, 1'b1, 1'b0, -1);
        idle(1);
        run_br(3'b111, 32'h0000_5000, 2, 1'b1, 1'b0, -1);
        idle(1);
        run_br(3'b100, 32'h0000_6000, 0, 1'b1, 1'b0, -1);
        idle(1);

        c0 = cyc;
        run_br(3'b101, 32'h0000_7000, WM + 4, 1'b0, 1'b0, -1);
        idle(2);
        check("wdog_err", {29'd0, a_err[c0+WM], a_err[c0+WM+1], a_stall[c0+WM+1]}, 32'd2);
        check("wdog_no_done", {31'd0, a_done[c0+WM+2]}, 32'd0);

        run_br(3'b000, 32'h0000_8000, WM, 1'b0, 1'b1, -1);
        idle(1);
        run_br(3'b001, 32'h0000_9000, WM + 1, 1'b0, 1'b0, -1);
        idle(1);

        c0 = cyc;
        run_br(3'b010, 32'h0000_A000, 0, 1'b0, 1'b0, -1);
        idle(2);
        check("ill_err_c1", {29'd0, a_err[c0+1], a_stall[c0], a_pcsel[c0+1]}, 32'd4);
        run_br(3'b011, 32'h0000_B000, 0, 1'b0, 1'b0, -1);
        idle(1);

        c0 = cyc;
        run_br(3'b100, 32'h0000_C000, 0, 1'b1, 1'b0, c0 + 2);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        idle(2);
        check("rst_abort_c2", {28'd0, a_pcsel[c0+2], a_flush[c0+2], a_done[c0+2], a_brun[c0+2]}, 32'd0);

        c0 = cyc;
        run_br(3'b001, 32'h0000_D000, 0, 1'b0, 1'b0, -1);
        idle(3);
        check("bne_after_rst", {29'd0, a_pcsel[c0+2], a_taken[c0+2], a_flush[c0+3]}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences the branch comparator (brun/brlt/breq) for one conditional branch at a time in the EX stage of the RISC-V pipeline.
- Decodes funct3 and drives brun: 1 = signed compare, 0 = unsigned compare.
- Waits for the data hazard unit to report forwarded operands valid, samples the comparator after one settle cycle, and resolves taken/not-taken.
- Stalls the front end while resolving; on a taken branch it redirects the PC and flushes IF/ID and ID/EX.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_if_id/flush_id_ex stay high after a taken branch (legal range 1..15).
- WAIT_MAX, 8, maximum cycles spent in WAIT before the watchdog fires (legal range 1..255).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  branch instruction present in EX; upstream holds it stable while stall=1.
- br_funct3  in  3  branch funct3 field.
- br_target  in  32  computed branch target address.
- opnd_ready  in  1  hazard unit: rs1/rs2 forwarded values are valid at the comparator.
- brlt  in  1  comparator less-than result.
- breq  in  1  comparator equal result.
- brun  out  1  comparator mode: 1 = signed, 0 = unsigned.
- stall  out  1  hold PC, IF/ID and ID/EX.
- pc_sel  out  1  select pc_target as the next PC (one-cycle pulse).
- pc_target  out  32  latched branch target.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- br_done  out  1  one-cycle pulse: branch resolved.
- br_taken  out  1  valid with br_done: 1 = taken.
- br_err  out  1  one-cycle pulse: illegal funct3 or WAIT watchdog expired.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; latches and counters cleared. Reset asserted mid-operation aborts immediately: no pc_sel, no flush, no br_done.
- States: IDLE, WAIT, CMP, FLUSH.
- Funct3 decode and taken condition:
  - 000 BEQ: taken = breq.
  - 001 BNE: taken = !breq.
  - 100 BLT: taken = brlt, brun=1.
  - 101 BGE: taken = !brlt, brun=1.
  - 110 BLTU: taken = brlt, brun=0.
  - 111 BGEU: taken = !brlt, brun=0.
  - brun=0 for BEQ/BNE.
  - 010/011 are illegal.
- IDLE:
  - On br_valid, latch funct3 and br_target (pc_target updates here).
  - Illegal funct3: pulse br_err next cycle, stay IDLE, no stall beyond the accept cycle.
  - opnd_ready=1 -> CMP; opnd_ready=0 -> WAIT with the wait counter cleared.
- WAIT:
  - Counter increments each cycle.
  - opnd_ready=1 -> CMP.
  - Counter reaches WAIT_MAX with opnd_ready still 0 -> br_err pulse, go to IDLE, not resolved.
  - If opnd_ready and the expiry coincide, opnd_ready wins.
- CMP (exactly 1 cycle):
  - brun is driven from the latched funct3, combinationally from state.
  - brlt/breq are sampled at the rising edge that ends CMP.
  - Not taken -> IDLE with br_done=1, br_taken=0 in the next cycle.
  - Taken -> FLUSH.
- FLUSH:
  - First cycle: pc_sel=1, br_done=1, br_taken=1.
  - flush_if_id and flush_id_ex are high for FLUSH_CYCLES consecutive cycles, then -> IDLE.
- stall = (IDLE & br_valid & legal funct3) | WAIT | CMP | FLUSH. It is low in the br_done cycle of a not-taken branch.
- brun holds its last value outside CMP; it is 0 after reset.
- br_valid while not IDLE is ignored. A new branch is accepted only in IDLE, so back-to-back branches resolve serially.
- Latency, opnd_ready=1 at accept:
  - Accept in cycle 0, CMP in cycle 1.
  - br_done in cycle 2.
  - Taken branch returns to IDLE in cycle 2+FLUSH_CYCLES.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches[CNT_W-1:0], stat_taken[CNT_W-1:0] and stat_stall_cyc[CNT_W-1:0].
  - stat_branches and stat_taken count resolved branches and taken branches.
  - stat_stall_cyc counts cycles spent in WAIT.
  - All three saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; the behaviour of every other output is identical.

Test Plan:
- BEQ taken, no hazard: funct3=000, br_target=0x0000_0100, opnd_ready=1, breq=1 -> cycle 2: pc_sel=1, pc_target=0x100, br_done=1, br_taken=1; flush_if_id/flush_id_ex high for cycles 2-3; IDLE at cycle 4.
- BLTU not taken: funct3=110, brlt=0 -> brun=0 in CMP; cycle 2: br_done=1, br_taken=0, no pc_sel, no flush, stall low.
- BGE with hazard: funct3=101, opnd_ready=0 for 3 cycles then 1, brlt=0 -> 3 WAIT cycles, brun=1 in CMP, taken redirect; stat_stall_cyc=3 when BRANCH_STATS_EN is defined.
- Watchdog: WAIT_MAX=8, opnd_ready held 0 -> br_err pulse after 8 WAIT cycles, return to IDLE, no br_done.
- Illegal funct3=010 -> br_err=1 next cycle, no pc_sel, state stays IDLE.
- Reset mid-FLUSH: rst_n=0 during the first flush cycle -> all outputs 0 immediately; after release, a new BNE with breq=0 resolves taken normally.
